costas_err_filter: RTL and testbench

COSTAS_ERR_FILTER -- requirements
Module: costas_err_filter

---
 rtl/costas_pkg.sv | 19 +
 rtl/iq_int_dump.sv | 68 ++++++
 rtl/costas_err_filter.sv | 152 +++++++++++++++
 tb/tb_costas_err_filter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/costas_pkg.sv
// costas_pkg: shared defaults and derived widths for the Costas error filter.
// Imported by iq_int_dump and costas_err_filter.
package costas_pkg;

   localparam int          DW_DEF        = 12;
   localparam int          N_LOG2_DEF    = 6;
   localparam int          KP_SHIFT_DEF  = 4;
   localparam int          KI_SHIFT_DEF  = 10;
   localparam logic [31:0] FREQ_NOM_DEF  = 32'h1B645A1C;
   localparam logic [31:0] FREQ_SPAN_DEF = 32'h00400000;

   // One bit for the negated sample, N_LOG2 bits of growth.
   localparam int ACC_W_DEF = DW_DEF + 1 + N_LOG2_DEF;

   function automatic int acc_w(int dw, int n_log2);
      return dw + 1 + n_log2;
   endfunction

endpackage

// File: rtl/iq_int_dump.sv
// iq_int_dump: mixes one arm with a square LO bit, integrates 2^N_LOG2 valid samples, dumps.
// Ports: din/din_valid/lo in; sum (acc+prod), fire (dumping sample), dump/dump_valid out.
module iq_int_dump
   import costas_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int N_LOG2 = N_LOG2_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      din,
   input  logic               din_valid,
   input  logic               lo,
   output logic [DW+N_LOG2:0] sum,
   output logic               fire,
   output logic [DW+N_LOG2:0] dump,
   output logic               dump_valid
);

   localparam int AW = acc_w(DW, N_LOG2);

   logic signed [DW:0] din_x;
   logic signed [DW:0] prod;
   logic [AW-1:0]      acc_q, acc_d;
   logic [AW-1:0]      dump_q, dump_d;
   logic [N_LOG2-1:0]  cnt_q, cnt_d;
   logic               dv_q, dv_d;

   always_comb begin
      // DW+1 bits so negating the most negative sample is exact.
      din_x  = {din[DW-1], din};
      prod   = lo ? din_x : -din_x;
      sum    = acc_q + {{N_LOG2{prod[DW]}}, prod};
      fire   = din_valid && (cnt_q == '1);
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      dump_d = dump_q;
      dv_d   = 1'b0;
      if (din_valid) begin
         cnt_d = cnt_q + 1'b1;
         if (fire) begin
            dump_d = sum;
            acc_d  = '0;
            dv_d   = 1'b1;
         end else begin
            acc_d  = sum;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         dump_q <= '0;
         dv_q   <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         dump_q <= dump_d;
         dv_q   <= dv_d;
      end
   end

   assign dump       = dump_q;
   assign dump_valid = dv_q;

endmodule

// File: rtl/costas_err_filter.sv
// costas_err_filter: Costas I/Q integrate-and-dump, phase error, PI loop filter, lock detect.
// Ports: din/din_valid, lo_s/lo_c, freeze in; phaseincr, i_dump/q_dump, dump_valid, lock out.
module costas_err_filter
   import costas_pkg::*;
#(
   parameter int          DW        = DW_DEF,
   parameter int          N_LOG2    = N_LOG2_DEF,
   parameter int          KP_SHIFT  = KP_SHIFT_DEF,
   parameter int          KI_SHIFT  = KI_SHIFT_DEF,
   parameter logic [31:0] FREQ_NOM  = FREQ_NOM_DEF,
   parameter logic [31:0] FREQ_SPAN = FREQ_SPAN_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DW-1:0]      din,
   input  logic               din_valid,
   input  logic               lo_s,
   input  logic               lo_c,
   input  logic               freeze,
   output logic [31:0]        phaseincr,
   output logic [DW+N_LOG2:0] i_dump,
   output logic [DW+N_LOG2:0] q_dump,
   output logic               dump_valid,
   output logic               lock
);

   localparam int AW = acc_w(DW, N_LOG2);
   localparam int EW = AW + 1;
   localparam int IW = 34;

   localparam logic [4:0]           LOCK_N = 5'd16;
   localparam logic signed [IW-1:0] NOM_S  = {2'b00, FREQ_NOM};
   localparam logic signed [IW-1:0] SPAN_S = {2'b00, FREQ_SPAN};
   localparam logic signed [IW-1:0] HI_S   = NOM_S + SPAN_S;
   localparam logic signed [IW-1:0] LO_S   = NOM_S - SPAN_S;
   localparam logic [31:0]          HI32   = FREQ_NOM + FREQ_SPAN;
   localparam logic [31:0]          LO32   = FREQ_NOM - FREQ_SPAN;

   logic [AW-1:0] i_sum, q_sum;
   logic          i_fire, q_fire, i_dv, q_dv, fire;

   logic signed [EW-1:0] q_x;
   logic signed [EW-1:0] e_q, e_d;
   logic [AW-1:0]        i_abs, q_abs;
   logic                 pass;
   logic [4:0]           lock_cnt_q, lock_cnt_d;
   logic                 lock_q, lock_d;

   logic signed [EW-1:0] e_ki, e_kp;
   logic signed [IW-1:0] e_ki_x, e_kp_x;
   logic signed [IW-1:0] integ_q, integ_d, integ_sum;
   logic signed [IW-1:0] psum;
   logic                 upd_q, upd_d;
   logic [31:0]          ph_q, ph_d;

   iq_int_dump #(
      .DW     (DW),
      .N_LOG2 (N_LOG2)
   ) u_i_arm (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .lo         (lo_c),
      .sum        (i_sum),
      .fire       (i_fire),
      .dump       (i_dump),
      .dump_valid (i_dv)
   );

   iq_int_dump #(
      .DW     (DW),
      .N_LOG2 (N_LOG2)
   ) u_q_arm (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .lo         (lo_s),
      .sum        (q_sum),
      .fire       (q_fire),
      .dump       (q_dump),
      .dump_valid (q_dv)
   );

   // Both arms share din_valid and reset, so their strobes coincide.
   assign fire       = i_fire & q_fire;
   assign dump_valid = i_dv & q_dv;

   always_comb begin
      q_x = {q_sum[AW-1], q_sum};
      e_d = e_q;
      if (fire) e_d = i_sum[AW-1] ? -q_x : q_x;

      i_abs = i_sum[AW-1] ? ~i_sum + 1'b1 : i_sum;
      q_abs = q_sum[AW-1] ? ~q_sum + 1'b1 : q_sum;
      pass  = q_abs < (i_abs >> 2);

      lock_cnt_d = lock_cnt_q;
      if (fire) begin
         if (!pass)                    lock_cnt_d = 5'd0;
         else if (lock_cnt_q < LOCK_N) lock_cnt_d = lock_cnt_q + 5'd1;
      end
      lock_d = (lock_cnt_d == LOCK_N);
   end

   // Integrator moves while dump_valid is high; phaseincr follows
   // one cycle later so it sees the updated integrator.
   always_comb begin
      e_ki      = e_q >>> KI_SHIFT;
      e_kp      = e_q >>> KP_SHIFT;
      e_ki_x    = {{(IW-EW){e_ki[EW-1]}}, e_ki};
      e_kp_x    = {{(IW-EW){e_kp[EW-1]}}, e_kp};
      integ_sum = integ_q + e_ki_x;
      integ_d   = integ_q;
      if (dump_valid && !freeze) begin
         if (integ_sum > SPAN_S)       integ_d = SPAN_S;
         else if (integ_sum < -SPAN_S) integ_d = -SPAN_S;
         else                          integ_d = integ_sum;
      end
      upd_d = dump_valid;
      psum  = NOM_S + integ_q + e_kp_x;
      ph_d  = ph_q;
      if (upd_q) begin
         if (psum > HI_S)      ph_d = HI32;
         else if (psum < LO_S) ph_d = LO32;
         else                  ph_d = psum[31:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q        <= '0;
         lock_cnt_q <= '0;
         lock_q     <= 1'b0;
         integ_q    <= '0;
         upd_q      <= 1'b0;
         ph_q       <= FREQ_NOM;
      end else begin
         e_q        <= e_d;
         lock_cnt_q <= lock_cnt_d;
         lock_q     <= lock_d;
         integ_q    <= integ_d;
         upd_q      <= upd_d;
         ph_q       <= ph_d;
      end
   end

   assign phaseincr = ph_q;
   assign lock      = lock_q;

endmodule

// File: tb/tb_costas_err_filter.sv
// tb_costas_err_filter: directed scoreboard bench for costas_err_filter.
// FREQ_SPAN is narrowed so the clamp is reachable in a short run.
module tb_costas_err_filter;

   localparam logic [31:0] NOM  = 32'h1B645A1C;
   localparam logic [31:0] SPAN = 32'h00004000;
   localparam longint      NOML  = longint'(NOM);
   localparam longint      SPANL = longint'(SPAN);

   typedef struct {
      longint i;
      longint q;
   } dump_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] din;
   logic        din_valid, lo_s, lo_c, freeze;
   logic [31:0] phaseincr;
   logic [18:0] i_dump, q_dump;
   logic        dump_valid, lock;

   int     errs = 0;
   int     checks = 0;
   dump_t  sb[$];
   longint m_acc_i, m_acc_q, m_e, m_integ, m_ph;
   int     m_cnt, m_lock_cnt;
   bit     m_s1, m_s2;
   int     cyc = 0;
   int     last_dv_cyc = 0;
   int     start_cyc;

   costas_err_filter #(
      .FREQ_SPAN (SPAN)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .lo_s       (lo_s),
      .lo_c       (lo_c),
      .freeze     (freeze),
      .phaseincr  (phaseincr),
      .i_dump     (i_dump),
      .q_dump     (q_dump),
      .dump_valid (dump_valid),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   function automatic longint clampl(longint v, longint lo, longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint absl(longint v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
      m_e = 0; m_integ = 0; m_ph = NOML;
      m_lock_cnt = 0; m_s1 = 0; m_s2 = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      rst_n = 1'b0; din_valid = 1'b0;
      #1;
      chk("rst_phaseincr", phaseincr, NOM);
      chk("rst_dump_valid", dump_valid, 0);
      chk("rst_lock", lock, 0);
      chk("rst_i_dump", $signed(i_dump), 0);
      chk("rst_q_dump", $signed(q_dump), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic drive(input bit v, input int d, input bit lc, input bit ls);
      longint pi, pq, ei, eq;
      bit     dumped;
      dump_t  got;
      dumped = 1'b0;
      ei = 0; eq = 0;
      din = d[11:0]; din_valid = v; lo_c = lc; lo_s = ls;
      if (v) begin
         pi = lc ? longint'(d) : -longint'(d);
         pq = ls ? longint'(d) : -longint'(d);
         if (m_cnt == 63) begin
            ei = m_acc_i + pi;
            eq = m_acc_q + pq;
            sb.push_back('{ei, eq});
            m_acc_i = 0; m_acc_q = 0; m_cnt = 0;
            dumped = 1'b1;
         end else begin
            m_acc_i += pi; m_acc_q += pq; m_cnt++;
         end
      end
      @(posedge clk); #1;
      cyc++;
      if (m_s2) begin
         m_ph = clampl(NOML + m_integ + (m_e >>> 4), NOML - SPANL, NOML + SPANL);
         m_s2 = 0;
      end
      if (m_s1) begin
         if (!freeze) m_integ = clampl(m_integ + (m_e >>> 10), -SPANL, SPANL);
         m_s1 = 0; m_s2 = 1;
      end
      if (dumped) begin
         m_e = (ei >= 0) ? eq : -eq;
         if (absl(eq) < (absl(ei) >> 2))
            m_lock_cnt = (m_lock_cnt >= 16) ? 16 : m_lock_cnt + 1;
         else
            m_lock_cnt = 0;
         m_s1 = 1;
      end
      chk("dump_valid", dump_valid, dumped);
      if (dump_valid === 1'b1) begin
         last_dv_cyc = cyc;
         chk("sb_nonempty", sb.size(), 1);
         if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("i_dump", $signed(i_dump), got.i);
            chk("q_dump", $signed(q_dump), got.q);
         end
      end
      chk("phaseincr", phaseincr, m_ph);
      chk("lock", lock, (m_lock_cnt == 16) ? 1 : 0);
   endtask

   initial begin
      rst_n = 1'b0; din = '0; din_valid = 1'b0;
      lo_s = 1'b0; lo_c = 1'b0; freeze = 1'b0;
      model_reset();
      #12;
      do_reset();

      // Idle: nothing dumps, phaseincr stays nominal.
      for (int k = 0; k < 20; k++) drive(0, 0, 1, 0);

      // Constant +100, I in phase, Q alternating: lock after 16 dumps.
      for (int k = 0; k < 16 * 64; k++) drive(1, 100, 1, k[0]);
      chk("lock_after_16", lock, 1);
      chk("i_dump_6400", $signed(i_dump), 6400);
      chk("q_dump_zero", $signed(q_dump), 0);

      // Full-scale negative sample, both LOs low.
      for (int k = 0; k < 64; k++) drive(1, -2048, 0, 0);
      chk("i_dump_fs", $signed(i_dump), 131072);
      chk("q_dump_fs", $signed(q_dump), 131072);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("ph_first_fs", phaseincr, NOM + 32'd8320);
      chk("lock_cleared", lock, 0);

      // Sustained positive error drives phaseincr into the clamp.
      for (int k = 0; k < 130 * 64; k++) drive(1, -2048, 0, 0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("ph_clamp_hi", phaseincr, NOM + SPAN);

      // Frozen integrator: only the proportional term moves.
      freeze = 1'b1;
      for (int k = 0; k < 3 * 64; k++) drive(1, -2048, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("ph_frozen", phaseincr, NOM + 32'd8192);
      freeze = 1'b0;
      for (int k = 0; k < 64; k++) drive(1, -2048, 0, 1);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("ph_unfrozen", phaseincr, NOM + 32'd8064);

      // Gapped valid: 64 valid samples across 128 cycles.
      start_cyc = cyc;
      for (int k = 0; k < 128; k++) drive(~k[0], 100, 1, 1);
      chk("gapped_dump_cycle", last_dv_cyc - start_cyc, 127);
      drive(0, 0, 1, 1);
      drive(0, 0, 1, 1);

      // Reset mid-integration discards the partial sum.
      for (int k = 0; k < 30; k++) drive(1, 700, 1, 1);
      do_reset();
      start_cyc = cyc;
      for (int k = 0; k < 64; k++) drive(1, 5, 1, 0);
      chk("post_rst_dump_cycle", last_dv_cyc - start_cyc, 64);
      chk("post_rst_i", $signed(i_dump), 320);
      chk("post_rst_q", $signed(q_dump), -320);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);
      chk("post_rst_ph", phaseincr, NOM - 32'd21);
      drive(0, 0, 0, 0);
      chk("sb_drained", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
